// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel strobe, x/y counters and sync/blank decodes.
// Optional 16-bit frame counter port enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int CLK_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          blanking,
    output logic          h_sync,
    output logic          v_sync,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ON     = 1'(H_POL);
    localparam logic          V_ON     = 1'(V_POL);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          div_last;
    logic          h_last;
    logic          v_last;

    assign div_last = (div_cnt == DIV_LAST);
    assign h_last   = (h_cnt == H_LAST);
    assign v_last   = (v_cnt == V_LAST);
    assign pix_ce   = en && div_last && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (en) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            if (div_last) begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end
            end
        end
    end

    // Decodes are forced to their idle levels while rst is held, even before the counters clear.
    always_comb begin
        x           = '0;
        y           = '0;
        de          = 1'b0;
        h_sync      = ~H_ON;
        v_sync      = ~V_ON;
        line_start  = 1'b0;
        frame_start = 1'b0;
        if (!rst) begin
            x           = h_cnt;
            y           = v_cnt;
            de          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            h_sync      = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? H_ON : ~H_ON;
            v_sync      = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? V_ON : ~V_ON;
            line_start  = pix_ce && (h_cnt == '0);
            frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);
        end
        blanking = ~de;
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pix_ce && h_last && v_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations checked every cycle against a pixel-index model.
module tb_video_timing_gen;

    localparam int N = 3;
    localparam int CD [N] = '{1, 4, 1};
    localparam int HA [N] = '{640, 16, 8};
    localparam int HF [N] = '{16, 2, 1};
    localparam int HS [N] = '{96, 3, 2};
    localparam int HB [N] = '{48, 2, 1};
    localparam int VA [N] = '{480, 5, 4};
    localparam int VF [N] = '{10, 1, 1};
    localparam int VS [N] = '{2, 2, 1};
    localparam int VB [N] = '{33, 1, 1};
    localparam int HP [N] = '{0, 0, 1};
    localparam int VP [N] = '{0, 0, 1};

    logic        clk;
    logic        rst_v [N];
    logic        en_v  [N];
    logic        pce_o [N];
    logic [11:0] x_o   [N];
    logic [11:0] y_o   [N];
    logic        de_o  [N];
    logic        bl_o  [N];
    logic        hs_o  [N];
    logic        vs_o  [N];
    logic        ls_o  [N];
    logic        fs_o  [N];
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fc_o  [N];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: clock phase, linear pixel index within the frame, frame count.
    int div_m [N] = '{0, 0, 0};
    int p_m   [N] = '{0, 0, 0};
    int fc_m  [N] = '{0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen #(.CW(12), .CLK_DIV(CD[0]), .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]),
        .H_BP(HB[0]), .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .H_POL(HP[0]), .V_POL(VP[0])) d0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .pix_ce(pce_o[0]), .x(x_o[0]), .y(y_o[0]),
        .de(de_o[0]), .blanking(bl_o[0]), .h_sync(hs_o[0]), .v_sync(vs_o[0]),
        .line_start(ls_o[0]), .frame_start(fs_o[0])
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_o[0])
`endif
    );

    video_timing_gen #(.CW(12), .CLK_DIV(CD[1]), .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]),
        .H_BP(HB[1]), .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .H_POL(HP[1]), .V_POL(VP[1])) d1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .pix_ce(pce_o[1]), .x(x_o[1]), .y(y_o[1]),
        .de(de_o[1]), .blanking(bl_o[1]), .h_sync(hs_o[1]), .v_sync(vs_o[1]),
        .line_start(ls_o[1]), .frame_start(fs_o[1])
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_o[1])
`endif
    );

    video_timing_gen #(.CW(12), .CLK_DIV(CD[2]), .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]),
        .H_BP(HB[2]), .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
        .H_POL(HP[2]), .V_POL(VP[2])) d2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .pix_ce(pce_o[2]), .x(x_o[2]), .y(y_o[2]),
        .de(de_o[2]), .blanking(bl_o[2]), .h_sync(hs_o[2]), .v_sync(vs_o[2]),
        .line_start(ls_o[2]), .frame_start(fs_o[2])
`ifdef VTG_FRAME_CNT_EN
        , .frame_cnt(fc_o[2])
`endif
    );

    function automatic int htot(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vtot(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_v[i]) begin
                div_m[i] <= 0;
                p_m[i]   <= 0;
                fc_m[i]  <= 0;
            end else if (en_v[i]) begin
                if (div_m[i] == CD[i] - 1) begin
                    div_m[i] <= 0;
                    if (p_m[i] == htot(i) * vtot(i) - 1) begin
                        p_m[i]  <= 0;
                        fc_m[i] <= (fc_m[i] + 1) % 65536;
                    end else begin
                        p_m[i] <= p_m[i] + 1;
                    end
                end else begin
                    div_m[i] <= div_m[i] + 1;
                end
            end
        end
    end

    task automatic chk(input int i, input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL d%0d %s: got %0d, expected %0d (t=%0t)", i, nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        int ex, ey, pce, ede, ehs, evs, els, efs, hsb, vsb;
        for (int i = 0; i < N; i++) begin
            pce = (!rst_v[i] && en_v[i] && div_m[i] == CD[i] - 1) ? 1 : 0;
            if (rst_v[i]) begin
                ex = 0; ey = 0; ede = 0; els = 0; efs = 0;
                ehs = 1 - HP[i];
                evs = 1 - VP[i];
            end else begin
                ex  = p_m[i] % htot(i);
                ey  = p_m[i] / htot(i);
                ede = (ex < HA[i] && ey < VA[i]) ? 1 : 0;
                hsb = HA[i] + HF[i];
                vsb = VA[i] + VF[i];
                ehs = (ex >= hsb && ex < hsb + HS[i]) ? HP[i] : 1 - HP[i];
                evs = (ey >= vsb && ey < vsb + VS[i]) ? VP[i] : 1 - VP[i];
                els = (pce == 1 && ex == 0) ? 1 : 0;
                efs = (els == 1 && ey == 0) ? 1 : 0;
            end
            chk(i, "x", int'(x_o[i]), ex);
            chk(i, "y", int'(y_o[i]), ey);
            chk(i, "pix_ce", int'(pce_o[i]), pce);
            chk(i, "de", int'(de_o[i]), ede);
            chk(i, "blanking", int'(bl_o[i]), 1 - ede);
            chk(i, "h_sync", int'(hs_o[i]), ehs);
            chk(i, "v_sync", int'(vs_o[i]), evs);
            chk(i, "line_start", int'(ls_o[i]), els);
            chk(i, "frame_start", int'(fs_o[i]), efs);
`ifdef VTG_FRAME_CNT_EN
            chk(i, "frame_cnt", int'(fc_o[i]), fc_m[i]);
`endif
        end
    endtask

    task automatic sample();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs0_n, hs0_first, hs0_last, de0_n, ls0_n, fs0_n;
        int pce1_first;
        int fs2_n, ls2_n, hs2_n, vs2_n, hs2_first, hs2_last;
        int found;

        hs0_n = 0; hs0_first = -1; hs0_last = -1; de0_n = 0; ls0_n = 0; fs0_n = 0;
        pce1_first = -1;
        fs2_n = 0; ls2_n = 0; hs2_n = 0; vs2_n = 0; hs2_first = -1; hs2_last = -1;

        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b1;
            en_v[i]  = 1'b1;
        end
        repeat (3) begin
            sample();
            chk(0, "rst de", int'(de_o[0]), 0);
            chk(0, "rst h_sync", int'(hs_o[0]), 1);
            tick();
        end
        for (int i = 0; i < N; i++) rst_v[i] = 1'b0;

        // Free run with en held high from reset release.
        for (int k = 0; k < 900; k++) begin
            sample();
            if (k == 0) begin
                chk(0, "first x", int'(x_o[0]), 0);
                chk(0, "first de", int'(de_o[0]), 1);
                chk(0, "first blanking", int'(bl_o[0]), 0);
                chk(0, "first h_sync", int'(hs_o[0]), 1);
            end
            if (k < 800) begin
                if (hs_o[0] == 1'b0) begin
                    hs0_n++;
                    if (hs0_first < 0) hs0_first = int'(x_o[0]);
                    hs0_last = int'(x_o[0]);
                end
                de0_n += int'(de_o[0]);
                ls0_n += int'(ls_o[0]);
                fs0_n += int'(fs_o[0]);
            end
            if (k == 799) chk(0, "x before wrap", int'(x_o[0]), 799);
            if (k == 800) begin
                chk(0, "x after wrap", int'(x_o[0]), 0);
                chk(0, "y after wrap", int'(y_o[0]), 1);
            end
            if (pce1_first < 0 && pce_o[1] == 1'b1) pce1_first = k;
            if (k == 4) chk(1, "x after first pix_ce", int'(x_o[1]), 1);
            if (k < 168) begin
                fs2_n += int'(fs_o[2]);
                ls2_n += int'(ls_o[2]);
                hs2_n += int'(hs_o[2]);
                vs2_n += int'(vs_o[2]);
                if (k < 12 && hs_o[2] == 1'b1) begin
                    if (hs2_first < 0) hs2_first = int'(x_o[2]);
                    hs2_last = int'(x_o[2]);
                end
            end
`ifdef VTG_FRAME_CNT_EN
            if (k == 0)   chk(2, "frame_cnt after reset", int'(fc_o[2]), 0);
            if (k == 168) chk(2, "frame_cnt two frames", int'(fc_o[2]), 2);
`endif
            tick();
        end
        chk(0, "h_sync low count", hs0_n, 96);
        chk(0, "h_sync first x", hs0_first, 656);
        chk(0, "h_sync last x", hs0_last, 751);
        chk(0, "de count", de0_n, 640);
        chk(0, "line_start count", ls0_n, 1);
        chk(0, "frame_start count", fs0_n, 1);
        chk(1, "first pix_ce index", pce1_first, 3);
        chk(2, "frame_start count", fs2_n, 2);
        chk(2, "line_start count", ls2_n, 14);
        chk(2, "h_sync high count", hs2_n, 28);
        chk(2, "v_sync high count", vs2_n, 24);
        chk(2, "h_sync first x", hs2_first, 9);
        chk(2, "h_sync last x", hs2_last, 10);

        // Freeze d0 at x=300 for 37 clocks.
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            sample();
            if (x_o[0] == 12'd299) found = 1;
            tick();
        end
        chk(0, "reach x=299", found, 1);
        en_v[0] = 1'b0;
        repeat (37) begin
            sample();
            chk(0, "frozen x", int'(x_o[0]), 300);
            chk(0, "frozen pix_ce", int'(pce_o[0]), 0);
            tick();
        end
        en_v[0] = 1'b1;
        sample();
        chk(0, "resume x", int'(x_o[0]), 300);
        tick();
        sample();
        chk(0, "resume x+1", int'(x_o[0]), 301);
        tick();

        // Reset pulse at x=700.
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            sample();
            if (x_o[0] == 12'd699) found = 1;
            tick();
        end
        chk(0, "reach x=699", found, 1);
        rst_v[0] = 1'b1;
        repeat (3) begin
            sample();
            chk(0, "mid rst x", int'(x_o[0]), 0);
            chk(0, "mid rst blanking", int'(bl_o[0]), 1);
            chk(0, "mid rst pix_ce", int'(pce_o[0]), 0);
            tick();
        end
        rst_v[0] = 1'b0;
        sample();
        chk(0, "post rst x", int'(x_o[0]), 0);
        chk(0, "post rst y", int'(y_o[0]), 0);
        chk(0, "post rst de", int'(de_o[0]), 1);
        tick();

        // Randomised enable gaps and occasional resets on all three generators.
        for (int n = 0; n < 5000; n++) begin
            for (int i = 0; i < N; i++) begin
                en_v[i]  = ($urandom_range(0, 9) < 8);
                rst_v[i] = ($urandom_range(0, 399) == 0);
            end
            sample();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480 sync block.
- Generalises resolution, porch/sync widths, sync polarity, pixel-clock divide ratio and counter width.
- Adds pixel enable strobe, data-enable, line/frame start pulses and a pause input.
- Feeds pixel generators and the TMDS/VGA output stage.
- Single clock domain.

Parameters:
- CW, 12, width of x/y outputs and internal counters; H_TOTAL and V_TOTAL must be <= 2^CW.
- CLK_DIV, 1, clk cycles per pixel (>=1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  advance enable; low freezes all counters
- pix_ce  out  1  one-clk pixel strobe
- x  out  CW  current horizontal count
- y  out  CW  current vertical count
- de  out  1  active video
- blanking  out  1  ~de
- h_sync  out  1  horizontal sync, polarity per H_POL
- v_sync  out  1  vertical sync, polarity per V_POL
- line_start  out  1  strobe at x==0
- frame_start  out  1  strobe at x==0,y==0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- div_cnt counts 0..CLK_DIV-1 when en=1, wrapping to 0; holds when en=0.
- pix_ce = en && div_cnt==CLK_DIV-1 && !rst. With CLK_DIV=1, pix_ce = en && !rst.
- On a clk edge with pix_ce=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 at the same edge h_cnt wraps.
- x=h_cnt, y=v_cnt.
- All other outputs are combinational decodes of the current counters. Ranges are half-open, with no off-by-one:
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - h_sync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise the inactive level.
  - v_sync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; independent of h_cnt.
  - line_start = pix_ce && h_cnt==0.
  - frame_start = line_start && v_cnt==0.
- Every pixel position persists exactly CLK_DIV clk cycles while en=1.
- Reset:
  - While rst=1: div_cnt, h_cnt and v_cnt load 0; x=0, y=0.
  - Outputs forced while rst=1: de=0, blanking=1, h_sync=~H_POL, v_sync=~V_POL, pix_ce=0, line_start=0, frame_start=0.
  - First clk after release: position (0,0) decoded normally (de=1, blanking=0, syncs inactive).
  - The first pix_ce comes CLK_DIV clks after release, if en=1.
- Reset mid-frame: counters return to 0 at the next edge; no partial-line completion.
- rst has priority over en.
- en=0: counters and outputs hold their last values; pix_ce=0; pulses suppressed.
- Resumption continues from the held div_cnt; no phase loss.
- Width: counters are CW bits; comparisons use CW-bit constants.

Optional Feature:
- Macro: VTG_FRAME_CNT_EN.
- Defined:
  - Adds port frame_cnt, out, 16 bits.
  - Increments (wrap 0xFFFF->0) on the edge where h_cnt and v_cnt both wrap.
  - Reset value 0; holds while en=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, CLK_DIV=1, en=1, release reset:
  - x increments every clk.
  - h_sync low exactly for x=656..751 (96 clks).
  - Line wraps after x=799.
  - de high for x 0..639 only.
- Defaults, full frame:
  - v_sync low exactly for y=490..491.
  - frame_start once per 420000 clks at (0,0).
  - line_start 525 times per frame.
- CLK_DIV=4: pix_ce every 4th clk; each x value held 4 clks; first pix_ce 4 clks after reset release.
- H_POL=1, V_POL=1, tiny mode (H 8/1/2/1, V 4/1/1/1):
  - h_sync high only at x=9..10.
  - v_sync high only at y=5.
  - Totals 12x7.
- en low for 37 clks mid-line at x=300:
  - x, y and div_cnt frozen; pix_ce=0.
  - Timing resumes at x=300 with the same phase.
- rst pulse at x=700, y=200:
  - Next clk: x=0, y=0.
  - All outputs at reset values during rst; normal decode after release.
  - With VTG_FRAME_CNT_EN: frame_cnt=0 after reset and =2 after two full frames.
